// File: rtl/softmax_pkg.sv
// Shared types, default parameters and helper functions for the streaming softmax row block.
//   state_t          : row FSM states (fill, activate, reciprocal, emit)
//   mode_t           : activation select (ReLU or max-subtracted base-2 exponential)
//   sum_width()      : width of the row accumulator for a given element width / row length
//   recip_lut_init() : contents of one reciprocal mantissa LUT entry
package softmax_pkg;

  typedef enum logic [1:0] {S_FILL, S_ACT, S_RECIP, S_EMIT} state_t;
  typedef enum logic {MODE_RELU = 1'b0, MODE_EXP2 = 1'b1} mode_t;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_FRAC_BITS      = 8;
  localparam int DEF_ROW_LEN        = 8;
  localparam int DEF_LUT_ADDR_WIDTH = 8;
  localparam int SUM_W              = DEF_DATA_WIDTH + $clog2(DEF_ROW_LEN);
  localparam int ONE                = 1 << DEF_FRAC_BITS;

  function automatic int sum_width(input int dw, input int rl);
    return dw + $clog2(rl);
  endfunction

  // round(2^(dw-1) / (1 + i/2^aw)) done in integers: 2^(dw-1+aw) / (2^aw + i), rounded half up.
  function automatic longint recip_lut_init(input int i, input int dw, input int aw);
    longint num;
    longint den;
    num = longint'(1) << (dw - 1 + aw);
    den = (longint'(1) << aw) + longint'(i);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/softmax_row_stream_recip.sv
// recip_lut_norm: reciprocal of the row sum in leading-one-normalised form.
//   clk, rst : clock, synchronous active-high reset
//   sum_in   : row sum (held stable by the caller for at least two cycles)
//   recip    : LUT mantissa 2^(DATA_WIDTH-1)/(1.m), valid 2 cycles after sum_in settles
//   p        : leading-one index of sum_in, aligned with recip
module recip_lut_norm
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int SUM_W          = 19,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int P_W            = $clog2(SUM_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SUM_W-1:0]      sum_in,
  output logic [DATA_WIDTH-1:0] recip,
  output logic [P_W-1:0]        p
);

  localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]     lut [LUT_DEPTH];
  logic [P_W-1:0]            p1_d, p1_q, p2_d, p2_q;
  logic [LUT_ADDR_WIDTH-1:0] idx1_d, idx1_q;
  logic [DATA_WIDTH-1:0]     recip_d, recip_q;
  logic [SUM_W-1:0]          norm;

  generate
    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
      assign lut[gi] = DATA_WIDTH'(recip_lut_init(gi, DATA_WIDTH, LUT_ADDR_WIDTH));
    end
  endgenerate

  always_comb begin
    p1_d = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (sum_in[i]) p1_d = P_W'(i);
    end
    // Shift the leading one up to the MSB; the bits right below it are the mantissa index.
    // Small sums are zero-filled from the right by the shift itself.
    norm    = sum_in << (P_W'(SUM_W - 1) - p1_d);
    idx1_d  = LUT_ADDR_WIDTH'(norm >> (SUM_W - 1 - LUT_ADDR_WIDTH));
    p2_d    = p1_q;
    recip_d = lut[idx1_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q    <= '0;
      idx1_q  <= '0;
      p2_q    <= '0;
      recip_q <= '0;
    end else begin
      p1_q    <= p1_d;
      idx1_q  <= idx1_d;
      p2_q    <= p2_d;
      recip_q <= recip_d;
    end
  end

  assign recip = recip_q;
  assign p     = p2_q;

endmodule

// File: rtl/softmax_row_stream.sv
// softmax_row_stream: buffers one score row, applies ReLU or exp2(x-max), normalises by the row sum
// through a reciprocal LUT and streams the weights back out.
//   clk, rst             : clock, synchronous active-high reset
//   mode                 : 0 ReLU / 1 exp2, latched with the first element of a row
//   in_valid/in_ready    : input element handshake; in_data is signed Q(FRAC_BITS)
//   in_last              : sender's end-of-row flag, only checked (err_len)
//   out_valid/out_ready  : output element handshake; out_data is unsigned Q(FRAC_BITS)
//   out_last             : marks the final element of the row
//   busy                 : low only when idle with no element of a new row accepted
//   err_len              : one-cycle pulse when in_last disagrees with the element position
module softmax_row_stream
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FRAC_BITS      = DEF_FRAC_BITS,
  parameter int ROW_LEN        = DEF_ROW_LEN,
  parameter int LUT_ADDR_WIDTH = DEF_LUT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_len
);

  localparam int DW  = DATA_WIDTH;
  localparam int SW  = sum_width(DATA_WIDTH, ROW_LEN);
  localparam int CW  = $clog2(ROW_LEN);
  localparam int PW  = $clog2(SW);
  localparam int SHW = $clog2(2 * DW + SW) + 1;
  localparam logic [DW:0]       ONE_X     = {{DW{1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [DW:0]       FRAC_MASK = ONE_X - {{DW{1'b0}}, 1'b1};
  localparam logic [DW:0]       K_LIMIT   = (DW + 1)'(DW);
  localparam logic [2*DW-1:0]   ONE_W     = {{(2 * DW - 1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [CW-1:0]     LAST_COL  = CW'(ROW_LEN - 1);

  state_t          state_d, state_q;
  mode_t           mode_d, mode_q;
  logic [CW-1:0]   col_d, col_q;
  logic [SW-1:0]   sum_d, sum_q;
  logic [DW-1:0]   max_d, max_q;
  logic            rc_d, rc_q;
  logic            zero_row_d, zero_row_q;
  logic            out_valid_d, out_valid_q;
  logic            err_len_d, err_len_q;

  logic [DW-1:0]   buf_q [ROW_LEN];
  logic            buf_we;
  logic [DW-1:0]   buf_wdata;
  logic [DW-1:0]   cur_x;

  logic [DW:0]     diff, k_val, frac, mant;
  logic [DW-1:0]   act;
  logic [DW-1:0]   recip;
  logic [PW-1:0]   p_val;
  logic [2*DW-1:0] prod, scaled;
  logic [SHW-1:0]  sh;

  recip_lut_norm #(
    .DATA_WIDTH    (DW),
    .SUM_W         (SW),
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
    .P_W           (PW)
  ) u_recip (
    .clk   (clk),
    .rst   (rst),
    .sum_in(sum_q),
    .recip (recip),
    .p     (p_val)
  );

  // During S_ACT this is the raw score, during S_EMIT it is the activated value.
  assign cur_x = buf_q[col_q];

  always_comb begin
    // d = max - x is never negative, so one extra bit is enough.
    diff  = {max_q[DW-1], max_q} - {cur_x[DW-1], cur_x};
    k_val = diff >> FRAC_BITS;
    frac  = diff & FRAC_MASK;
    mant  = ONE_X - (frac >> 1);
    if (mode_q == MODE_RELU)  act = cur_x[DW-1] ? '0 : cur_x;
    else if (k_val >= K_LIMIT) act = '0;
    else                       act = DW'(mant >> k_val);
  end

  assign prod   = {{DW{1'b0}}, cur_x} * {{DW{1'b0}}, recip};
  assign sh     = SHW'(DW - 1 - FRAC_BITS) + SHW'(p_val);
  assign scaled = prod >> sh;

  always_comb begin
    if (!out_valid_q || zero_row_q) out_data = '0;
    else if (scaled > ONE_W)        out_data = DW'(ONE_W);
    else                            out_data = scaled[DW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    col_d       = col_q;
    sum_d       = sum_q;
    max_d       = max_q;
    rc_d        = rc_q;
    zero_row_d  = zero_row_q;
    out_valid_d = out_valid_q;
    err_len_d   = 1'b0;
    buf_we      = 1'b0;
    buf_wdata   = act;
    unique case (state_q)
      S_FILL: begin
        if (in_valid) begin
          buf_we    = 1'b1;
          buf_wdata = in_data;
          err_len_d = in_last ^ (col_q == LAST_COL);
          // The max is tracked in both modes; ReLU simply never looks at it.
          if (col_q == '0) begin
            mode_d = mode_t'(mode);
            max_d  = in_data;
          end else if ($signed(in_data) > $signed(max_q)) begin
            max_d = in_data;
          end
          if (col_q == LAST_COL) begin
            state_d = S_ACT;
            col_d   = '0;
            sum_d   = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_ACT: begin
        buf_we = 1'b1;
        sum_d  = sum_q + SW'(act);
        if (col_q == LAST_COL) begin
          state_d = S_RECIP;
          col_d   = '0;
          rc_d    = 1'b0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_RECIP: begin
        // sum_q is frozen here; the LUT pipeline needs exactly these two cycles.
        rc_d       = 1'b1;
        zero_row_d = (sum_q == '0);
        if (rc_q) begin
          state_d     = S_EMIT;
          out_valid_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (col_q == LAST_COL) begin
            state_d     = S_FILL;
            col_d       = '0;
            out_valid_d = 1'b0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      mode_q      <= MODE_RELU;
      col_q       <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      rc_q        <= 1'b0;
      zero_row_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      rc_q        <= rc_d;
      zero_row_q  <= zero_row_d;
      out_valid_q <= out_valid_d;
      err_len_q   <= err_len_d;
    end
  end

  // Row storage carries no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[col_q] <= buf_wdata;
  end

  assign in_ready  = (state_q == S_FILL);
  assign busy      = !((state_q == S_FILL) && (col_q == '0));
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (col_q == LAST_COL);
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_softmax_row_stream.sv
module tb_softmax_row_stream;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int RL = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, mode, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last, busy, err_len;
  logic [DW-1:0] in_data, out_data;

  softmax_row_stream #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .ROW_LEN(RL), .LUT_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct { longint d; bit last; } exp_t;
  exp_t   exp_q[$];
  longint got_q[$];
  int     n_cmp = 0, n_fail = 0;
  int     cyc = 0, err_cnt = 0, last_in_cyc = 0, first_out_cyc = 0;
  bit     stall_en = 1'b0, prev_stall = 1'b0, prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  bit lp_std[RL] = '{0, 0, 0, 1};
  bit lp_bad[RL] = '{0, 1, 0, 1};

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: activation, row sum, reciprocal mantissa and scaling straight from the arithmetic rules.
  task automatic model_row(input bit m, input int x[RL]);
    longint a[RL];
    longint s, mx, d, k, f, p, idx, den, lut, v;
    exp_t e;
    s  = 0;
    mx = x[0];
    for (int i = 1; i < RL; i++) if (x[i] > mx) mx = x[i];
    for (int i = 0; i < RL; i++) begin
      if (!m) a[i] = (x[i] > 0) ? x[i] : 0;
      else begin
        d = mx - x[i];
        k = d / (1 << FB);
        f = d % (1 << FB);
        a[i] = (k >= DW) ? 0 : (((1 << FB) - f / 2) >> k);
      end
      s += a[i];
    end
    p = 0;
    for (int b = 0; b < 40; b++) if (((s >> b) & 1) == 1) p = b;
    if (p >= AW) idx = (s >> (p - AW)) % (1 << AW);
    else         idx = (s << (AW - p)) % (1 << AW);
    den = (1 << AW) + idx;
    lut = ((longint'(1) << (DW - 1 + AW)) + den / 2) / den;
    for (int i = 0; i < RL; i++) begin
      if (s == 0) v = 0;
      else begin
        v = (a[i] * lut) >> (DW - 1 + p - FB);
        if (v > (1 << FB)) v = 1 << FB;
      end
      e.d = v;
      e.last = (i == RL - 1);
      exp_q.push_back(e);
    end
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (err_len) err_cnt++;
      if (in_valid && in_ready) last_in_cyc = cyc;
      if (out_valid && !prev_valid) first_out_cyc = cyc;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        $display("out: data=%0d last=%0d cycle=%0d", out_data, out_last, cyc);
        got_q.push_back(longint'(out_data));
        chk("out_data_known", longint'($isunknown(out_data)), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got data %0d, required no output", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("model_data", out_data, e.d);
          chk("model_last", out_last, e.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
    prev_valid = out_valid;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_elems(input bit m, input int x[RL], input bit lp[RL], input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(x[i]);
      in_last  = lp[i];
      mode     = (i == 0) ? m : ~m;  // later elements carry the other mode; it must be ignored
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_row(input string name, input bit m, input int x[RL], input bit lp[RL],
                         input bit use_lit, input int lit[RL], input int exp_err);
    got_q.delete();
    err_cnt = 0;
    model_row(m, x);
    send_elems(m, x, lp, RL);
    @(negedge clk);
    chk({name, "_busy"}, busy, 1);
    chk({name, "_in_ready_low"}, in_ready, 0);
    for (int c = 0; c < 300 && got_q.size() < RL; c++) begin
      @(negedge clk);
      #1;
    end
    chk({name, "_count"}, got_q.size(), RL);
    chk({name, "_latency"}, first_out_cyc - last_in_cyc, RL + 3);
    if (use_lit) begin
      for (int i = 0; i < RL && i < got_q.size(); i++) chk({name, "_lit"}, got_q[i], lit[i]);
    end
    repeat (4) @(negedge clk);
    chk({name, "_err_len"}, err_cnt, exp_err);
    chk({name, "_count_after"}, got_q.size(), RL);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_len", err_len, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_row("relu_ones", 1'b0, '{256, 256, 256, 256}, lp_std, 1'b1, '{64, 64, 64, 64}, 0);
    run_row("relu_mixed", 1'b0, '{-256, 512, 0, -1}, lp_std, 1'b1, '{0, 256, 0, 0}, 0);
    run_row("relu_zero", 1'b0, '{-5, -5, -5, -5}, lp_std, 1'b1, '{0, 0, 0, 0}, 0);
    run_row("exp_peak", 1'b1, '{256, 0, 0, 0}, lp_std, 1'b1, '{102, 51, 51, 51}, 0);
    run_row("exp_flat", 1'b1, '{0, 0, 0, 0}, lp_std, 1'b1, '{64, 64, 64, 64}, 0);
    run_row("exp_spread", 1'b1, '{1000, -3000, 500, 999}, lp_std, 1'b0, '{0, 0, 0, 0}, 0);
    run_row("exp_extreme", 1'b1, '{32767, -32768, 0, 32767}, lp_std, 1'b0, '{0, 0, 0, 0}, 0);
    run_row("relu_ramp", 1'b0, '{100, 200, 300, -400}, lp_std, 1'b0, '{0, 0, 0, 0}, 0);

    stall_en = 1'b1;
    run_row("stall_errlen", 1'b0, '{256, 256, 256, 256}, lp_bad, 1'b1, '{64, 64, 64, 64}, 1);
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of filling a row: that row must vanish.
    send_elems(1'b1, '{256, 256, 256, 256}, lp_std, 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    run_row("after_rst", 1'b0, '{256, 256, 256, 256}, lp_std, 1'b1, '{64, 64, 64, 64}, 0);

    repeat (10) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
